dma_block_writer: RTL and testbench

DMA initiator on the far side of the processor's hold/acknowledge interface. It requests the bus with `HLD` and waits for `HLDA`. It then streams a block of words from a valid/ready source into processor memory over `DMA_Address`/`DMA_data`/`dma_we`. Finally it releases the bus and signals completion. It sits outside the `mips` top, on the same `clk`, and drives the processor's `HLD` input.

---
 rtl/dma_block_writer_pkg.sv | 18 +
 rtl/dma_block_writer_if.sv | 35 +++
 rtl/dma_block_writer_out_buffer.sv | 56 +++++
 rtl/dma_block_writer.sv | 148 ++++++++++++++
 tb/tb_dma_block_writer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_block_writer_pkg.sv
// Shared types and defaults for the DMA block writer and the processor top.
package dma_block_writer_pkg;

  localparam int unsigned DMA_ADDR_W  = 16;
  localparam int unsigned DMA_DATA_W  = 16;
  localparam int unsigned DMA_LEN_W   = 8;
  localparam int unsigned DMA_TIMEOUT = 255;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_REQ     = 3'd1;
  localparam state_t ST_XFER    = 3'd2;
  localparam state_t ST_FLUSH   = 3'd3;
  localparam state_t ST_RELEASE = 3'd4;

endpackage

// File: rtl/dma_block_writer_if.sv
// Command, source stream, hold/acknowledge and memory-write signals of the DMA block writer.
interface dma_block_writer_if
  import dma_block_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = DMA_ADDR_W,
  parameter int unsigned DATA_W = DMA_DATA_W,
  parameter int unsigned LEN_W  = DMA_LEN_W
) ();

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic              HLD;
  logic              HLDA;
  logic [ADDR_W-1:0] DMA_Address;
  logic [DATA_W-1:0] DMA_data;
  logic              dma_we;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, base_addr, length, src_valid, src_data, HLDA,
    output src_ready, HLD, DMA_Address, DMA_data, dma_we, busy, done, err
  );

  modport slave (
    output start, base_addr, length, src_valid, src_data, HLDA,
    input  src_ready, HLD, DMA_Address, DMA_data, dma_we, busy, done, err
  );

endinterface

// File: rtl/dma_block_writer_out_buffer.sv
// One-entry write buffer: holds the address/data pair presented to memory until it retires.
module dma_out_buffer
  import dma_block_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = DMA_ADDR_W,
  parameter int unsigned DATA_W = DMA_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              retire_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A load in the same cycle as a retire replaces the retiring word.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
    end else if (retire_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/dma_block_writer.sv
// DMA initiator: requests the bus via HLD/HLDA, streams a block from a valid/ready
// source into memory, then releases the bus and pulses done (or err on grant timeout).
module dma_block_writer
  import dma_block_writer_pkg::*;
#(
  parameter int unsigned ADDR_W  = DMA_ADDR_W,
  parameter int unsigned DATA_W  = DMA_DATA_W,
  parameter int unsigned LEN_W   = DMA_LEN_W,
  parameter int unsigned TIMEOUT = DMA_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  dma_block_writer_if.master  bus
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              hld_q, hld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              buf_valid;
  logic              buf_clear;
  logic              accept;
  logic              retire;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  assign bus.src_ready = (state_q == ST_XFER) && bus.HLDA && (!buf_valid || bus.HLDA);
  assign bus.dma_we    = buf_valid && ((state_q == ST_XFER) || (state_q == ST_FLUSH));
  assign accept        = bus.src_valid && bus.src_ready;
  assign retire        = bus.dma_we && bus.HLDA;

  // Re-grant returns to FLUSH once every word has been accepted, else to XFER.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    wait_d    = wait_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    buf_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.length == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = bus.base_addr;
            rem_d   = bus.length;
            wait_d  = '0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus.HLDA) begin
          state_d = (rem_q == '0) ? ST_FLUSH : ST_XFER;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          err_d     = 1'b1;
          buf_clear = 1'b1;
          rem_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_XFER: begin
        if (!bus.HLDA) begin
          wait_d  = '0;
          state_d = ST_REQ;
        end else if (accept) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!bus.HLDA) begin
          wait_d  = '0;
          state_d = ST_REQ;
        end else if (retire) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!bus.HLDA) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    hld_d  = (state_d == ST_REQ) || (state_d == ST_XFER) || (state_d == ST_FLUSH);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wait_q  <= '0;
      hld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      hld_q   <= hld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  dma_out_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (buf_clear),
    .load_i   (accept),
    .retire_i (retire),
    .addr_i   (addr_q),
    .data_i   (bus.src_data),
    .valid_o  (buf_valid),
    .addr_o   (buf_addr),
    .data_o   (buf_data)
  );

  assign bus.DMA_Address = buf_addr;
  assign bus.DMA_data    = buf_data;
  assign bus.HLD         = hld_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_dma_block_writer.sv
// Directed bench for dma_block_writer: a processor model grants HLDA, a source feeds words,
// and a scoreboard checks every retired memory write in order.
module tb_dma_block_writer;

  logic clk;
  logic rst_n;

  dma_block_writer_if #(.ADDR_W(16), .DATA_W(16), .LEN_W(8)) bus ();

  dma_block_writer #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .LEN_W   (8),
    .TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] src_q[$];
  logic [31:0] exp_q[$];
  logic        hlda_block = 1'b0;
  logic        src_en = 1'b1;
  logic        src_acc_pending = 1'b0;
  logic        hld_seen = 1'b0;
  logic        we_seen = 1'b0;
  int          acc_cnt = 0;
  int          wr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_stats();
    acc_cnt  = 0;
    wr_cnt   = 0;
    hld_seen = 1'b0;
    we_seen  = 1'b0;
  endtask

  // Queue source words and the writes they must produce, in order.
  task automatic load_block(input logic [15:0] base, input int n, input logic [15:0] seed);
    logic [15:0] a;
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      d = seed + 16'(i);
      src_q.push_back(d);
      exp_q.push_back({a, d});
    end
  endtask

  task automatic wait_done(input string tag, input int k0, input int budget,
                           output int lat, output logic hld_prev);
    logic prev;
    prev     = bus.HLD;
    lat      = -1;
    hld_prev = 1'b1;
    for (int k = k0 + 1; k <= k0 + budget; k++) begin
      tick();
      if (bus.done) begin
        lat      = k;
        hld_prev = prev;
        break;
      end
      prev = bus.HLD;
    end
    check({tag, "_done_seen"}, 32'(lat > 0), 32'd1);
  endtask

  // Processor grants within the cycle; source presents queue head; writes retire on dma_we && HLDA.
  always @(negedge clk) begin
    logic [31:0] e;
    if (src_acc_pending && src_q.size() > 0) void'(src_q.pop_front());
    bus.HLDA      = bus.HLD && !hlda_block;
    bus.src_valid = src_en && (src_q.size() > 0);
    bus.src_data  = (src_q.size() > 0) ? src_q[0] : 16'h0;
    #1;
    src_acc_pending = bus.src_valid && bus.src_ready;
    if (src_acc_pending) acc_cnt++;
    if (bus.HLD) hld_seen = 1'b1;
    if (bus.dma_we) we_seen = 1'b1;
    if (bus.dma_we && bus.HLDA) begin
      wr_cnt++;
      check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.DMA_Address), 32'(e[31:16]));
        check("wr_data", 32'(bus.DMA_data), 32'(e[15:0]));
      end
    end
  end

  initial begin
    int   lat;
    logic hp;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    bus.HLDA      = 1'b0;
    rst_n         = 1'b0;
    repeat (3) tick();

    check("rst_hld",       32'(bus.HLD), 32'd0);
    check("rst_dma_we",    32'(bus.dma_we), 32'd0);
    check("rst_src_ready", 32'(bus.src_ready), 32'd0);
    check("rst_busy",      32'(bus.busy), 32'd0);
    check("rst_done",      32'(bus.done), 32'd0);
    check("rst_err",       32'(bus.err), 32'd0);
    check("rst_addr",      32'(bus.DMA_Address), 32'd0);
    check("rst_data",      32'(bus.DMA_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // 4-word block at 0x0100
    clear_stats();
    load_block(16'h0100, 4, 16'hA000);
    bus.base_addr = 16'h0100; bus.length = 8'd4; bus.start = 1'b1;
    tick();
    check("a_hld_rise", 32'(bus.HLD), 32'd1);
    check("a_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done("a", 1, 40, lat, hp);
    check("a_latency", 32'(lat), 32'd8);
    check("a_hld_low_before_done", 32'(hp), 32'd0);
    check("a_hld_at_done", 32'(bus.HLD), 32'd0);
    check("a_writes", 32'(wr_cnt), 32'd4);
    check("a_sb_empty", 32'(exp_q.size()), 32'd0);
    tick();
    check("a_done_pulse", 32'(bus.done), 32'd0);
    check("a_idle", 32'(bus.busy), 32'd0);

    // zero-length command
    clear_stats();
    bus.length = 8'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("b_done", 32'(bus.done), 32'd1);
    check("b_busy", 32'(bus.busy), 32'd0);
    tick();
    check("b_done_pulse", 32'(bus.done), 32'd0);
    check("b_no_hld", 32'(hld_seen), 32'd0);

    // grant never arrives
    clear_stats();
    hlda_block = 1'b1;
    src_en     = 1'b0;
    bus.base_addr = 16'h0200; bus.length = 8'd2; bus.start = 1'b1;
    begin
      int hld_cnt;
      logic err_seen;
      hld_cnt  = 0;
      err_seen = 1'b0;
      for (int k = 1; k <= 30; k++) begin
        tick();
        bus.start = 1'b0;
        if (bus.err) begin
          err_seen = 1'b1;
          check("c_hld_at_err", 32'(bus.HLD), 32'd0);
          check("c_busy_at_err", 32'(bus.busy), 32'd0);
          break;
        end
        if (bus.HLD) hld_cnt++;
      end
      check("c_err_seen", 32'(err_seen), 32'd1);
      check("c_hld_cycles", 32'(hld_cnt), 32'd8);
    end
    tick();
    check("c_err_pulse", 32'(bus.err), 32'd0);
    check("c_no_dma_we", 32'(we_seen), 32'd0);
    check("c_no_done", 32'(bus.done), 32'd0);
    hlda_block = 1'b0;
    src_en     = 1'b1;

    // grant drops for 3 cycles while word 2 of 5 is buffered
    clear_stats();
    load_block(16'h0300, 5, 16'hB000);
    bus.base_addr = 16'h0300; bus.length = 8'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 10 && acc_cnt < 2; k++) tick();
    check("d_word2_buffered", 32'(acc_cnt), 32'd2);
    hlda_block = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("d_we_suppressed", 32'(bus.dma_we), 32'd0);
    end
    check("d_writes_held", 32'(wr_cnt), 32'd1);
    hlda_block = 1'b0;
    wait_done("d", 0, 40, lat, hp);
    check("d_writes", 32'(wr_cnt), 32'd5);
    check("d_sb_empty", 32'(exp_q.size()), 32'd0);

    // address wrap
    clear_stats();
    load_block(16'hFFFE, 3, 16'hC000);
    bus.base_addr = 16'hFFFE; bus.length = 8'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("e", 1, 40, lat, hp);
    check("e_latency", 32'(lat), 32'd7);
    check("e_writes", 32'(wr_cnt), 32'd3);
    check("e_sb_empty", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a transfer
    clear_stats();
    load_block(16'h0400, 6, 16'hD000);
    bus.base_addr = 16'h0400; bus.length = 8'd6; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 10 && acc_cnt < 2; k++) tick();
    check("f_in_xfer", 32'(acc_cnt >= 2), 32'd1);
    rst_n = 1'b0;
    tick();
    check("f_hld_drop", 32'(bus.HLD), 32'd0);
    check("f_busy_drop", 32'(bus.busy), 32'd0);
    check("f_no_done", 32'(bus.done), 32'd0);
    tick();
    check("f_no_done_2", 32'(bus.done), 32'd0);
    src_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    tick();

    clear_stats();
    load_block(16'h0500, 2, 16'hE000);
    bus.base_addr = 16'h0500; bus.length = 8'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("g", 1, 40, lat, hp);
    check("g_latency", 32'(lat), 32'd6);
    check("g_writes", 32'(wr_cnt), 32'd2);
    check("g_sb_empty", 32'(exp_q.size()), 32'd0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
